// File: rtl/rtc_bk_stream_pkg.sv
// Shared definitions for the RTC backup streamer and the mapper RTC loaders.
// Holds the record geometry, the FSM state encoding and a counter-width helper.
package rtc_bk_stream_pkg;

  // Data words per RTC record; the commit write goes to the address just past them.
  localparam int unsigned RTC_NUM_WORDS   = 5;
  localparam int unsigned RTC_COMMIT_ADDR = RTC_NUM_WORDS;

  typedef logic [2:0] rtc_state_t;

  localparam rtc_state_t StIdle     = 3'd0;
  localparam rtc_state_t StLdLo     = 3'd1;
  localparam rtc_state_t StLdHi     = 3'd2;
  localparam rtc_state_t StLdWr     = 3'd3;
  localparam rtc_state_t StLdCommit = 3'd4;
  localparam rtc_state_t StSvSend   = 3'd5;
  localparam rtc_state_t StDone     = 3'd6;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned rtc_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_bk_pack.sv
// Byte-to-word packer for the RTC load direction.
// Ports:
//   clk_sys, reset  clock, asynchronous active-high reset
//   clr             restart at word 0 (start of a new record)
//   lo_en, hi_en    capture ld_byte as the low / high byte of the current word
//   adv             current word has been written; step the word counter
//   ld_byte         incoming file byte
//   word            packed {hi, lo}
//   word_idx        index of the word being assembled
//   last_word       word_idx is the final word of the record
module rtc_bk_pack
  import rtc_bk_stream_pkg::*;
#(
  parameter int unsigned NUM_WORDS = RTC_NUM_WORDS,
  parameter int unsigned CntW      = rtc_cnt_w(NUM_WORDS)
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            clr,
  input  logic            lo_en,
  input  logic            hi_en,
  input  logic            adv,
  input  logic [7:0]      ld_byte,
  output logic [15:0]     word,
  output logic [CntW-1:0] word_idx,
  output logic            last_word
);

  logic [7:0]      lo_q, lo_d;
  logic [7:0]      hi_q, hi_d;
  logic [CntW-1:0] idx_q, idx_d;

  assign last_word = (idx_q == CntW'(NUM_WORDS - 1));

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    idx_d = idx_q;
    if (lo_en) lo_d = ld_byte;
    if (hi_en) hi_d = ld_byte;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      idx_d = last_word ? '0 : idx_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lo_q  <= '0;
      hi_q  <= '0;
      idx_q <= '0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      idx_q <= idx_d;
    end
  end

  assign word     = {hi_q, lo_q};
  assign word_idx = idx_q;

endmodule

// File: rtl/rtc_bk_stream.sv
// Moves cartridge RTC backup state between the HPS save-file byte stream and a mapper.
// Load: 2*NUM_WORDS bytes are packed into words written at addresses 0..NUM_WORDS-1,
// followed by a commit write (data 0) at address NUM_WORDS.
// Save: timestamp/savedtime are snapshotted on the accepting edge and streamed as bytes.
// Ports:
//   clk_sys, reset                  clock, asynchronous active-high reset
//   ld_start/ld_byte/ld_valid/ld_ready   load byte stream in
//   abort                           cancel the running sequence
//   bk_rtc_wr/bk_addr/bk_data       word writes to the mapper
//   sv_start, rtc_inuse, rtc_timestamp, rtc_savedtime   save request and mapper RTC state
//   sv_byte/sv_valid/sv_ready       save byte stream out
//   busy, done, err                 status
module rtc_bk_stream
  import rtc_bk_stream_pkg::*;
#(
  parameter int unsigned NUM_WORDS = RTC_NUM_WORDS,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              abort,
  output logic              bk_rtc_wr,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [15:0]       bk_data,
  input  logic              sv_start,
  input  logic              rtc_inuse,
  input  logic [31:0]       rtc_timestamp,
  input  logic [47:0]       rtc_savedtime,
  output logic [7:0]        sv_byte,
  output logic              sv_valid,
  input  logic              sv_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned WordCntW = rtc_cnt_w(NUM_WORDS);
  localparam int unsigned SvCntW   = rtc_cnt_w(2 * NUM_WORDS);
  localparam int unsigned SnapW    = 16 * NUM_WORDS;

  rtc_state_t         state_q, state_d;
  logic [SnapW-1:0]   snap_q, snap_d;
  logic [SvCntW-1:0]  sv_idx_q, sv_idx_d;
  logic               sv_valid_q, sv_valid_d;
  logic               err_q, err_d;

  logic                pk_clr, pk_lo, pk_hi, pk_adv, pk_last;
  logic [15:0]         pk_word;
  logic [WordCntW-1:0] pk_idx;

  logic ld_hs, sv_hs, sv_last;

  rtc_bk_pack #(
    .NUM_WORDS (NUM_WORDS),
    .CntW      (WordCntW)
  ) u_pack (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clr       (pk_clr),
    .lo_en     (pk_lo),
    .hi_en     (pk_hi),
    .adv       (pk_adv),
    .ld_byte   (ld_byte),
    .word      (pk_word),
    .word_idx  (pk_idx),
    .last_word (pk_last)
  );

  assign ld_ready = (state_q == StLdLo) || (state_q == StLdHi);
  assign ld_hs    = ld_valid && ld_ready;
  assign sv_hs    = sv_valid_q && sv_ready;
  assign sv_last  = (sv_idx_q == SvCntW'(2 * NUM_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    sv_idx_d   = sv_idx_q;
    sv_valid_d = 1'b0;
    err_d      = 1'b0;
    pk_clr     = 1'b0;
    pk_lo      = 1'b0;
    pk_hi      = 1'b0;
    pk_adv     = 1'b0;

    case (state_q)
      StIdle: begin
        if (sv_start) begin
          // Save wins a simultaneous request; the load is rejected.
          snap_d   = SnapW'({rtc_savedtime, rtc_timestamp});
          sv_idx_d = '0;
          state_d  = rtc_inuse ? StSvSend : StDone;
          err_d    = ld_start;
        end else if (ld_start) begin
          pk_clr  = 1'b1;
          state_d = StLdLo;
        end
      end
      StLdLo: begin
        if (ld_hs) begin
          pk_lo   = 1'b1;
          state_d = StLdHi;
        end
      end
      StLdHi: begin
        if (ld_hs) begin
          pk_hi   = 1'b1;
          state_d = StLdWr;
        end
      end
      StLdWr: begin
        pk_adv  = 1'b1;
        state_d = pk_last ? StLdCommit : StLdLo;
      end
      StLdCommit: state_d = StDone;
      StSvSend: begin
        // Valid is registered, so it first rises one cycle into SV_SEND.
        sv_valid_d = 1'b1;
        if (sv_hs) begin
          sv_idx_d = sv_last ? '0 : sv_idx_q + SvCntW'(1);
          if (sv_last) begin
            sv_valid_d = 1'b0;
            state_d    = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      if (ld_start || sv_start) err_d = 1'b1;
      // Abort overrides whatever the case above decided, including a completing handshake.
      if (abort) begin
        state_d    = StIdle;
        err_d      = 1'b1;
        sv_valid_d = 1'b0;
        sv_idx_d   = sv_idx_q;
        pk_lo      = 1'b0;
        pk_hi      = 1'b0;
        pk_adv     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      sv_idx_q   <= '0;
      sv_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      sv_idx_q   <= sv_idx_d;
      sv_valid_q <= sv_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bk_rtc_wr = 1'b0;
    bk_addr   = '0;
    bk_data   = '0;
    if (state_q == StLdWr) begin
      bk_rtc_wr = 1'b1;
      bk_addr   = ADDR_W'(pk_idx);
      bk_data   = pk_word;
    end else if (state_q == StLdCommit) begin
      bk_rtc_wr = 1'b1;
      bk_addr   = ADDR_W'(NUM_WORDS);
    end
  end

  assign sv_valid = sv_valid_q;
  assign sv_byte  = sv_valid_q ? snap_q[{sv_idx_q, 3'b000} +: 8] : 8'h00;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign err      = err_q;

endmodule

// File: tb/tb_rtc_bk_stream.sv
module tb_rtc_bk_stream;

  localparam int unsigned NW = 5;
  localparam int unsigned AW = 17;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ld_start, ld_valid, ld_ready, abort;
  logic [7:0]    ld_byte;
  logic          bk_rtc_wr;
  logic [AW-1:0] bk_addr;
  logic [15:0]   bk_data;
  logic          sv_start, rtc_inuse, sv_valid, sv_ready;
  logic [31:0]   rtc_timestamp;
  logic [47:0]   rtc_savedtime;
  logic [7:0]    sv_byte;
  logic          busy, done, err;

  rtc_bk_stream #(
    .NUM_WORDS (NW),
    .ADDR_W    (AW)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ld_start      (ld_start),
    .ld_byte       (ld_byte),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .abort         (abort),
    .bk_rtc_wr     (bk_rtc_wr),
    .bk_addr       (bk_addr),
    .bk_data       (bk_data),
    .sv_start      (sv_start),
    .rtc_inuse     (rtc_inuse),
    .rtc_timestamp (rtc_timestamp),
    .rtc_savedtime (rtc_savedtime),
    .sv_byte       (sv_byte),
    .sv_valid      (sv_valid),
    .sv_ready      (sv_ready),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Passive monitor: mapper writes and status pulses.
  logic [AW+15:0] wr_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int vld_cnt  = 0;

  always @(negedge clk_sys) begin
    if (bk_rtc_wr) wr_q.push_back({bk_addr, bk_data});
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (sv_valid) vld_cnt++;
  end

  task automatic settle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("settle_idle", busy, 0);
    tick();
    tick();
  endtask

  // abort_at: abort right after this many bytes were accepted (-1: never).
  task automatic do_load(input logic [7:0] b[10], input bit hold_valid, input int abort_at,
                         input bit poke_sv, input string tag);
    logic [AW+15:0] exp_q[$];
    int  k = 0;
    int  cyc = 0;
    int  d0, e0, nwords;
    bit  hs, aborted, poked;
    aborted = 1'b0;
    poked   = 1'b0;
    wr_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    while (k < 10 && cyc < 300 && !aborted) begin
      ld_byte  = b[k];
      ld_valid = hold_valid ? 1'b1 : ($urandom_range(3) != 0);
      if (poke_sv && !poked && k == 3) begin
        sv_start = 1'b1;
        poked    = 1'b1;
      end
      @(negedge clk_sys);
      hs = ld_valid && ld_ready;
      tick();
      sv_start = 1'b0;
      cyc++;
      if (hs) begin
        k++;
        if (k == abort_at) begin
          ld_valid = 1'b0;
          abort    = 1'b1;
          tick();
          abort    = 1'b0;
          aborted  = 1'b1;
          check({tag, "_abort_busy"}, busy, 0);
        end
      end
    end
    ld_valid = 1'b0;
    check({tag, "_in_time"}, cyc < 300, 1);
    settle();
    nwords = aborted ? abort_at / 2 : NW;
    for (int i = 0; i < nwords; i++) exp_q.push_back({AW'(i), b[2*i+1], b[2*i]});
    if (!aborted) exp_q.push_back({AW'(NW), 16'h0000});
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), wr_q[i], exp_q[i]);
    check({tag, "_done"}, done_cnt - d0, aborted ? 0 : 1);
    check({tag, "_err"}, err_cnt - e0, (aborted || poke_sv) ? 1 : 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on byte 2.
  task automatic do_save(input logic [31:0] ts, input logic [47:0] st, input bit inuse,
                         input int mode, input bit both, input string tag);
    logic [79:0] snap;
    logic [7:0]  exp_b[$];
    logic [7:0]  rx_q[$];
    int d0, e0, v0;
    int stall = 0;
    int cyc = 0;
    bit fin = 1'b0;
    snap = {st, ts};
    if (inuse) for (int n = 0; n < 2 * NW; n++) exp_b.push_back(8'(snap >> (8 * n)));
    d0 = done_cnt;
    e0 = err_cnt;
    v0 = vld_cnt;
    rtc_timestamp = ts;
    rtc_savedtime = st;
    rtc_inuse     = inuse;
    sv_start      = 1'b1;
    ld_start      = both;
    tick();
    sv_start      = 1'b0;
    ld_start      = 1'b0;
    rtc_timestamp = $urandom;
    rtc_savedtime = {16'($urandom), $urandom};
    rtc_inuse     = 1'($urandom);
    while (!fin && cyc < 300) begin
      case (mode)
        0:       sv_ready = 1'b1;
        1:       sv_ready = ($urandom_range(2) != 0);
        default: sv_ready = !(rx_q.size() == 2 && stall < 3);
      endcase
      @(negedge clk_sys);
      if (sv_valid) begin
        if (rx_q.size() < exp_b.size())
          check($sformatf("%s_byte%0d", tag, rx_q.size()), sv_byte, exp_b[rx_q.size()]);
        else
          check({tag, "_overrun"}, sv_valid, 0);
        if (sv_ready) rx_q.push_back(sv_byte);
        else if (mode == 2) stall++;
      end
      if (done) begin
        check({tag, "_done_busy"}, busy, 1);
        fin = 1'b1;
      end
      tick();
      cyc++;
    end
    sv_ready = 1'b0;
    check({tag, "_in_time"}, fin, 1);
    settle();
    check({tag, "_nbytes"}, rx_q.size(), exp_b.size());
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_err"}, err_cnt - e0, both ? 1 : 0);
    if (!inuse) check({tag, "_no_valid"}, vld_cnt - v0, 0);
    if (mode == 2) check({tag, "_stall"}, stall, 3);
  endtask

  logic [7:0] bytes[10];

  initial begin
    reset = 1'b1;
    ld_start = 1'b0; ld_byte = 8'h00; ld_valid = 1'b0; abort = 1'b0;
    sv_start = 1'b0; rtc_inuse = 1'b0; rtc_timestamp = '0; rtc_savedtime = '0;
    sv_ready = 1'b0;
    #12;
    check("rst_ld_ready", ld_ready, 0);
    check("rst_bk", {bk_rtc_wr, bk_addr, bk_data}, 0);
    check("rst_sv", {sv_valid, sv_byte}, 0);
    check("rst_status", {busy, done, err}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Directed load with ld_valid held high.
    for (int i = 0; i < 10; i++) bytes[i] = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00;
    do_load(bytes, 1'b1, -1, 1'b0, "ld_fixed");

    // Directed save and backpressured save.
    do_save(32'h11223344, 48'hAABBCCDDEEFF, 1'b1, 0, 1'b0, "sv_fixed");
    do_save(32'h11223344, 48'hAABBCCDDEEFF, 1'b1, 2, 1'b0, "sv_stall");

    // Abort after the fifth byte: words 0-1 stay written, no commit.
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    do_load(bytes, 1'b0, 5, 1'b0, "ld_abort");

    // Simultaneous starts, and a save from a mapper without RTC.
    do_save($urandom, {16'($urandom), $urandom}, 1'b1, 1, 1'b1, "sv_both");
    do_save($urandom, {16'($urandom), $urandom}, 1'b0, 0, 1'b0, "sv_noinuse");

    // Start request while busy is rejected without disturbing the load.
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    do_load(bytes, 1'b0, -1, 1'b1, "ld_poke");

    // Reset while waiting for a high byte.
    wr_q.delete();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_byte  = 8'h5A;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    check("rst_mid_pre_ready", ld_ready, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_wr", bk_rtc_wr, 0);
    check("rst_mid_ready", ld_ready, 0);
    check("rst_mid_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_nowrite", wr_q.size(), 0);
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    do_load(bytes, 1'b0, -1, 1'b0, "ld_after_rst");

    // Randomized records in both directions.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
      do_load(bytes, 1'b0, -1, 1'b0, $sformatf("ld_rand%0d", r));
      do_save($urandom, {16'($urandom), $urandom}, 1'b1, 1, 1'b0, $sformatf("sv_rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
